// File: rtl/memory_port_arbiter.sv
// Two-requester memory port arbiter: instruction vs data onto one memory port.
// Optional ROUND_ROBIN_EN: fair tie-break; otherwise data wins every tie.
module memory_port_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_read,
  input  logic [BUS_WIDTH-1:0] inst_address,
  output logic [BUS_WIDTH-1:0] inst_read_data,
  output logic                 inst_response,
  input  logic                 data_read,
  input  logic                 data_write,
  input  logic [BUS_WIDTH-1:0] data_address,
  input  logic [BUS_WIDTH-1:0] data_write_data,
  output logic [BUS_WIDTH-1:0] data_read_data,
  output logic                 data_response,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_write_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data,
  input  logic                 mem_response,
  output logic [1:0]           owner
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BUSY_INST = 2'b01,
    BUSY_DATA = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   inst_req, data_req, pick_data;

  assign inst_req = inst_read;
  assign data_req = data_read | data_write;

`ifdef ROUND_ROBIN_EN
  // 1 = data was served last, so instruction wins the next tie
  logic last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (mem_response && state_q == BUSY_INST)
      last_owner_d = 1'b0;
    else if (mem_response && state_q == BUSY_DATA)
      last_owner_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_owner_q <= 1'b1;
    else        last_owner_q <= last_owner_d;
  end

  assign pick_data = ~last_owner_q;
`else
  assign pick_data = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (inst_req && data_req)
          state_d = pick_data ? BUSY_DATA : BUSY_INST;
        else if (inst_req)
          state_d = BUSY_INST;
        else if (data_req)
          state_d = BUSY_DATA;
      end
      BUSY_INST, BUSY_DATA: begin
        if (mem_response) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    inst_response  = 1'b0;
    data_response  = 1'b0;
    unique case (state_q)
      BUSY_INST: begin
        mem_read      = inst_read;
        mem_address   = inst_address;
        inst_response = mem_response;
      end
      BUSY_DATA: begin
        mem_write      = data_write;
        mem_read       = data_read & ~data_write;
        mem_address    = data_address;
        mem_write_data = data_write_data;
        data_response  = mem_response;
      end
      default: ;
    endcase
  end

  assign owner          = state_q;
  assign inst_read_data = mem_read_data;
  assign data_read_data = mem_read_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter.
// Tie-break expectations follow ROUND_ROBIN_EN when defined.
module tb_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_read;
  logic [31:0] inst_address;
  logic [31:0] inst_read_data;
  logic        inst_response;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [31:0] data_read_data;
  logic        data_response;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_response;
  logic [1:0]  owner;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(.BUS_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .inst_read(inst_read),
    .inst_address(inst_address),
    .inst_read_data(inst_read_data),
    .inst_response(inst_response),
    .data_read(data_read),
    .data_write(data_write),
    .data_address(data_address),
    .data_write_data(data_write_data),
    .data_read_data(data_read_data),
    .data_response(data_response),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_response(mem_response),
    .owner(owner)
  );

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] own, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic rd,
                      input logic wr);
    exp_t e;
    e.own = own; e.addr = addr; e.wdata = wdata;
    e.rd = rd; e.wr = wr;
    q.push_back(e);
  endtask

  // Memory side: wait for a strobe, answer 2 cycles later
  task automatic serve(input logic [31:0] rdata, input bit drop);
    exp_t e;
    int   lat = 0;
    while (!(mem_read | mem_write) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("strobe_lat", lat, 1);
    chk("sb_nonempty", q.size() != 0, 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("owner", owner, e.own);
    chk("mem_address", mem_address, e.addr);
    chk("mem_read", mem_read, e.rd);
    chk("mem_write", mem_write, e.wr);
    chk("mem_write_data", mem_write_data, e.wdata);
    repeat (2) @(negedge clk);
    chk("owner_hold", owner, e.own);
    mem_response  = 1'b1;
    mem_read_data = rdata;
    #1;
    chk("inst_response", inst_response, e.own == 2'b01);
    chk("data_response", data_response, e.own == 2'b10);
    chk("inst_read_data", inst_read_data, rdata);
    chk("data_read_data", data_read_data, rdata);
    @(negedge clk);
    mem_response = 1'b0;
    chk("gap_idle", owner, 2'b00);
    if (drop) begin
      if (e.own == 2'b01) inst_read = 1'b0;
      else begin
        data_read  = 1'b0;
        data_write = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    inst_read       = 1'b1;
    inst_address    = 32'h1234;
    data_read       = 1'b1;
    data_write      = 1'b1;
    data_address    = 32'h5678;
    data_write_data = 32'h9abc;
    mem_read_data   = 32'h0;
    mem_response    = 1'b1;
    #3;
    chk("rst_owner_async", owner, 2'b00);
    chk("rst_mem_read_async", mem_read, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_owner", owner, 2'b00);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_inst_resp", inst_response, 1'b0);
    chk("rst_data_resp", data_response, 1'b0);
    inst_read    = 1'b0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    mem_response = 1'b0;
    reset        = 1'b1;
    @(negedge clk);

    inst_read    = 1'b1;
    inst_address = 32'h100;
    push(2'b01, 32'h100, 32'h0, 1'b1, 1'b0);
    serve(32'hDEADBEEF, 1'b1);
    @(negedge clk);

    data_write      = 1'b1;
    data_address    = 32'h2000;
    data_write_data = 32'hCAFEF00D;
    push(2'b10, 32'h2000, 32'hCAFEF00D, 1'b0, 1'b1);
    serve(32'h0, 1'b1);
    @(negedge clk);

    data_read       = 1'b1;
    data_write      = 1'b1;
    data_address    = 32'h2004;
    data_write_data = 32'h11223344;
    push(2'b10, 32'h2004, 32'h11223344, 1'b0, 1'b1);
    serve(32'h0, 1'b1);
    @(negedge clk);

    data_read       = 1'b1;
    data_address    = 32'h2008;
    data_write_data = 32'h0;
    push(2'b10, 32'h2008, 32'h0, 1'b1, 1'b0);
    serve(32'h55AA55AA, 1'b1);
    @(negedge clk);

    inst_read    = 1'b1;
    inst_address = 32'h500;
    @(negedge clk);
    chk("drop_owner", owner, 2'b01);
    chk("drop_strobe_on", mem_read, 1'b1);
    inst_read = 1'b0;
    #1;
    chk("drop_strobe_off", mem_read, 1'b0);
    @(negedge clk);
    chk("drop_owner_hold", owner, 2'b01);
    mem_response = 1'b1;
    #1;
    chk("drop_inst_resp", inst_response, 1'b1);
    chk("drop_data_resp", data_response, 1'b0);
    @(negedge clk);
    mem_response = 1'b0;
    chk("drop_idle", owner, 2'b00);

    mem_response = 1'b1;
    #1;
    chk("idle_inst_resp", inst_response, 1'b0);
    chk("idle_data_resp", data_response, 1'b0);
    @(negedge clk);
    mem_response = 1'b0;
    chk("idle_owner", owner, 2'b00);

    data_read    = 1'b1;
    data_address = 32'h600;
    @(negedge clk);
    chk("mid_owner", owner, 2'b10);
    reset        = 1'b0;
    mem_response = 1'b1;
    #1;
    chk("mid_rst_owner", owner, 2'b00);
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_addr", mem_address, 32'h0);
    chk("mid_rst_data_resp", data_response, 1'b0);
    @(negedge clk);
    data_read = 1'b0;
    reset     = 1'b1;
    #1;
    chk("post_rst_data_resp", data_response, 1'b0);
    chk("post_rst_inst_resp", inst_response, 1'b0);
    @(negedge clk);
    mem_response = 1'b0;
    chk("post_rst_owner", owner, 2'b00);

    inst_read       = 1'b1;
    inst_address    = 32'h300;
    data_read       = 1'b1;
    data_address    = 32'h400;
    data_write_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
      if (i % 2 == 0) push(2'b01, 32'h300, 32'h0, 1'b1, 1'b0);
      else            push(2'b10, 32'h400, 32'h0, 1'b1, 1'b0);
`else
      push(2'b10, 32'h400, 32'h0, 1'b1, 1'b0);
`endif
    end
    for (int i = 0; i < 4; i++) serve(32'hA0 + i, 1'b0);
    inst_read = 1'b0;
    data_read = 1'b0;
    @(negedge clk);
    chk("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, width of address, write-data and read-data buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports inst_read  input  1, inst_address  input  BUS_WIDTH, inst_read_data  output  BUS_WIDTH, inst_response  output  1 (instruction requester).
REQ-005 SHALL have ports data_read  input  1, data_write  input  1, data_address  input  BUS_WIDTH, data_write_data  input  BUS_WIDTH, data_read_data  output  BUS_WIDTH, data_response  output  1 (data requester).
REQ-006 SHALL have ports mem_read  output  1, mem_write  output  1, mem_address  output  BUS_WIDTH, mem_write_data  output  BUS_WIDTH, mem_read_data  input  BUS_WIDTH, mem_response  input  1 (shared memory).
REQ-007 SHALL have port owner  output  2  current grant: 00 idle, 01 instruction, 10 data.

Function
REQ-008 SHALL implement states IDLE, BUSY_INST, BUSY_DATA; owner encodes the state.
REQ-009 Requests SHALL be level: inst_read for instruction; data_read or data_write for data; requester holds them until its response.
REQ-010 In IDLE with exactly one requester active, the FSM SHALL enter that requester's BUSY state on the next edge.
REQ-011 In IDLE with both active, the winner SHALL be chosen per REQ-021/REQ-022.
REQ-012 In BUSY_x, mem_address and mem_write_data SHALL be driven combinationally from the owner's inputs; in IDLE both SHALL be 0.
REQ-013 In BUSY_INST, mem_read SHALL equal inst_read and mem_write SHALL be 0.
REQ-014 In BUSY_DATA, mem_write SHALL equal data_write, and mem_read SHALL equal data_read AND NOT data_write (write wins a simultaneous read/write).
REQ-015 mem_response in BUSY_x SHALL be forwarded combinationally, same cycle, to the owner's response output only; the non-owner's response SHALL stay 0.
REQ-016 On a cycle with mem_response in BUSY_x, the FSM SHALL return to IDLE on the next edge; no re-grant in that same edge.
REQ-017 Latency: request first seen in IDLE at edge N, mem strobe valid in cycle after N; minimum inter-transaction gap one IDLE cycle.
REQ-018 If the owner drops its request before mem_response, the FSM SHALL stay in BUSY_x with strobes low until mem_response, then return to IDLE; no response is lost or misrouted.
REQ-019 mem_response in IDLE SHALL be ignored; both response outputs SHALL stay 0.
REQ-020 inst_read_data and data_read_data SHALL both mirror mem_read_data at all times; validity is qualified only by the respective response.

Configuration
REQ-021 With macro ROUND_ROBIN_EN defined, a 1-bit last_owner register SHALL record each completed grant, and on simultaneous requests the requester not last served SHALL win; last_owner resets to data, so instruction wins the first tie.
REQ-022 Without ROUND_ROBIN_EN, data SHALL always win simultaneous requests and no last_owner register SHALL exist.

Reset
REQ-023 While reset is low, the FSM SHALL be IDLE, owner 00, and mem_read, mem_write, inst_response, data_response, mem_address, mem_write_data all 0, independent of clk.
REQ-024 Reset asserted mid-transaction SHALL abandon it; a mem_response arriving after reset release in IDLE SHALL be ignored per REQ-019.
REQ-025 Release of reset SHALL take effect on the first rising clk edge after reset goes high.

Verification
REQ-026 inst_read=1, inst_address=0x100, memory responds 2 cycles after strobe with 0xDEADBEEF -> owner=01, mem_read=1, mem_address=0x100, inst_response=1 with inst_read_data=0xDEADBEEF, data_response=0.
REQ-027 data_write=1, data_address=0x2000, data_write_data=0xCAFEF00D -> owner=10, mem_write=1, mem_write_data=0xCAFEF00D, data_response pulses with mem_response.
REQ-028 Both requesters active every cycle for 4 transactions -> with ROUND_ROBIN_EN grants inst,data,inst,data; without it data,data,data,data while inst starves.
REQ-029 data_read=1 and data_write=1 together -> mem_write=1, mem_read=0.
REQ-030 Reset driven low in BUSY_DATA before mem_response, then mem_response pulsed after release -> all outputs 0 during reset, owner=00 afterwards, no response forwarded.
